// File: rtl/rp_err_latch_pkg.sv
// Shared definitions for the RPxx drive error registers (ER1/ER2/ER3).
package rp_err_latch_pkg;

  // Host write behaviour for the writable bits.
  typedef enum logic {
    WR_LOAD = 1'b0,  // write loads data
    WR_W1C  = 1'b1   // write-one-to-clear
  } wr_mode_e;

  // ER1 bit positions
  localparam int ER1_DCK  = 15;
  localparam int ER1_UNS  = 14;
  localparam int ER1_OPI  = 13;
  localparam int ER1_DTE  = 12;
  localparam int ER1_WLE  = 11;
  localparam int ER1_IAE  = 10;
  localparam int ER1_AOE  = 9;
  localparam int ER1_HCRC = 8;
  localparam int ER1_HCE  = 7;
  localparam int ER1_ECH  = 6;
  localparam int ER1_WCF  = 5;
  localparam int ER1_FER  = 4;
  localparam int ER1_PAR  = 3;
  localparam int ER1_RMR  = 2;
  localparam int ER1_ILR  = 1;
  localparam int ER1_ILF  = 0;

  // Default masks per register
  localparam logic [15:0] ER1_WRMASK  = 16'hFFFF;
  localparam logic [15:0] ER1_INHMASK = 16'h0100;
  localparam logic [15:0] ER2_WRMASK  = 16'hFFFF;
  localparam logic [15:0] ER2_INHMASK = 16'h0000;
  localparam logic [15:0] ER3_WRMASK  = 16'hFFFF;
  localparam logic [15:0] ER3_INHMASK = 16'h0000;

  // Ceiling log2, minimum 1 so index ports never collapse to zero width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rp_lsb_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted input bit.
module rp_lsb_enc
  import rp_err_latch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDXW  = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDXW-1:0]  idx_o,
  output logic             vld_o
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDXW'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rp_err_latch.sv
// RPxx drive error register: sticky per-bit error latch with host write,
// inhibit-gated bits, summary error, attention pulse, first-error capture
// and a saturating error-event counter.
module rp_err_latch
  import rp_err_latch_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] WRMASK  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] INHMASK = WIDTH'(16'h0100),
  parameter bit               W1C     = 1'b0,
  parameter int               CNTW    = 8,
  parameter int               IDXW    = clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             drvclr_i,
  input  logic [WIDTH-1:0] set_i,
  input  logic             inh_i,
  input  logic             wr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             cnt_clr_i,
  output logic [WIDTH-1:0] er_o,
  output logic             err_o,
  output logic             ata_o,
  output logic             first_vld_o,
  output logic [IDXW-1:0]  first_idx_o,
  output logic [CNTW-1:0]  evt_cnt_o
);

  localparam wr_mode_e MODE = W1C ? WR_W1C : WR_LOAD;

  logic [WIDTH-1:0] er_q, er_d;
  logic [WIDTH-1:0] set_eff, new_err;
  logic             ata_q;
  logic             first_vld_q;
  logic [IDXW-1:0]  first_idx_q;
  logic [CNTW-1:0]  cnt_q;
  logic [IDXW-1:0]  new_idx;
  logic             new_any;
  logic             clr_any;
  logic             wr_go;

  assign clr_any = clr_i | drvclr_i;
  assign wr_go   = wr_i & wr_en_i;
  assign set_eff = set_i & ~(INHMASK & {WIDTH{inh_i}});
  assign new_err = set_eff & ~er_q;

  // Per-bit next state: clear > set > write > hold.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic wr_val;
    assign wr_val = (MODE == WR_W1C) ? (er_q[g] & ~wr_data_i[g]) : wr_data_i[g];
    assign er_d[g] = clr_any                ? 1'b0 :
                     set_eff[g]             ? 1'b1 :
                     (wr_go && WRMASK[g])   ? wr_val :
                                              er_q[g];
  end

  rp_lsb_enc #(.WIDTH(WIDTH), .IDXW(IDXW)) u_enc (
    .vec_i (new_err),
    .idx_o (new_idx),
    .vld_o (new_any)
  );

  // Error bits and attention pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      er_q  <= '0;
      ata_q <= 1'b0;
    end else begin
      er_q  <= er_d;
      ata_q <= new_any & ~clr_any;
    end
  end

  // First-error capture; a write that empties the register also drops it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
    end else if (clr_any) begin
      first_vld_q <= 1'b0;
    end else if (new_any && !first_vld_q) begin
      first_vld_q <= 1'b1;
      first_idx_q <= new_idx;
    end else if (wr_go && (er_d == '0)) begin
      first_vld_q <= 1'b0;
    end
  end

  // Saturating count of cycles with at least one new error; drvclr keeps it.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= new_any ? CNTW'(1) : '0;
    end else if (new_any && (cnt_q != {CNTW{1'b1}})) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign er_o        = er_q;
  assign err_o       = |er_q;
  assign ata_o       = ata_q;
  assign first_vld_o = first_vld_q;
  assign first_idx_o = first_idx_q;
  assign evt_cnt_o   = cnt_q;

endmodule
